// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package definitions;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CLEAR,
        LD_LOAD,
        LD_CHECK,
        LD_RUN
    } loader_state_e;

    // An all-zero word is the MIPS NOP (sll $0,$0,0).
    localparam logic [31:0] NOP_WORD = '0;

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_ram
    import definitions::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streaming instruction-memory loader: clears, loads and releases the core from reset.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import definitions::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_csum
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    loader_state_e     state_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   len_reg;
    logic              s_ready_reg;
    logic              busy_reg;
    logic              cpu_rst_reg;
    logic              done_reg;
    logic              err_len_reg;
    logic [ADDR_W:0]   cnt_next;
    logic              accept;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_reg;
    logic              err_csum_reg;
`endif

    assign accept   = s_valid && s_ready_reg;
    assign cnt_next = cnt_reg + ONE_C;

    // The shared counter addresses the RAM in both CLEAR and LOAD.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cnt_reg[ADDR_W-1:0];
        ram_wdata = DATA_W'(NOP_WORD);
        if (state_reg == LD_CLEAR) begin
            ram_we = 1'b1;
        end else if (state_reg == LD_LOAD && accept) begin
            ram_we    = 1'b1;
            ram_wdata = s_data;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LD_IDLE;
            cnt_reg      <= '0;
            len_reg      <= '0;
            s_ready_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            cpu_rst_reg  <= 1'b1;
            done_reg     <= 1'b0;
            err_len_reg  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
            err_csum_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                LD_IDLE, LD_RUN: begin
                    if (load_start) begin
                        cpu_rst_reg <= 1'b1;
                        if (load_len > DEPTH_C) begin
                            err_len_reg <= 1'b1;
                            state_reg   <= LD_IDLE;
                        end else begin
                            len_reg     <= load_len;
                            cnt_reg     <= '0;
                            err_len_reg <= 1'b0;
                            busy_reg    <= 1'b1;
                            state_reg   <= LD_CLEAR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_reg     <= '0;
                            err_csum_reg <= 1'b0;
`endif
                        end
                    end
                end
                LD_CLEAR: begin
                    if (cnt_reg == LAST_C) begin
                        cnt_reg <= '0;
                        if (len_reg == '0) begin
                            busy_reg    <= 1'b0;
                            cpu_rst_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            state_reg   <= LD_RUN;
                        end else begin
                            s_ready_reg <= 1'b1;
                            state_reg   <= LD_LOAD;
                        end
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                LD_LOAD: begin
                    if (accept) begin
                        cnt_reg <= cnt_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg <= csum_reg ^ s_data;
                        if (cnt_next == len_reg) begin
                            state_reg <= LD_CHECK;
                        end
`else
                        if (cnt_next == len_reg) begin
                            s_ready_reg <= 1'b0;
                            busy_reg    <= 1'b0;
                            cpu_rst_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            state_reg   <= LD_RUN;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                LD_CHECK: begin
                    if (accept) begin
                        s_ready_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        if (s_data == csum_reg) begin
                            cpu_rst_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            state_reg   <= LD_RUN;
                        end else begin
                            err_csum_reg <= 1'b1;
                            state_reg    <= LD_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_reg <= LD_IDLE;
                end
            endcase
        end
    end

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign fetch_instr = (busy_reg || cpu_rst_reg || ({1'b0, fetch_addr} >= DEPTH_C))
                         ? DATA_W'(NOP_WORD) : ram_rdata;

    assign s_ready = s_ready_reg;
    assign busy    = busy_reg;
    assign cpu_rst = cpu_rst_reg;
    assign done    = done_reg;
    assign err_len = err_len_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_csum = err_csum_reg;
`else
    assign err_csum = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction-memory loader for the pipelined MIPS core. It replaces hierarchical ROM pokes and `$readmemb` preloading with a synthesizable streaming load path. A program is accepted word-by-word over a valid/ready handshake, unloaded words are zero-filled (NOP), and the core is held in reset until the image is complete. It sits between an external program source (UART bridge, bench driver) and the core's fetch stage, replacing `rom0`.

## Interface

Parameters:
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 64: instruction words stored.
- `ADDR_W`, default `$clog2(DEPTH)`: fetch/write address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_start` in 1: one-cycle request to begin a new load.
- `load_len` in ADDR_W+1: number of program words, sampled with `load_start`.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word this cycle.
- `s_data` in DATA_W: stream word.
- `fetch_addr` in ADDR_W: word address from the core PC.
- `fetch_instr` out DATA_W: instruction at `fetch_addr`.
- `cpu_rst` out 1: hold-reset to the core; low only in RUN.
- `busy` out 1: high in CLEAR, LOAD and CHECK.
- `done` out 1: one-cycle pulse on entry to RUN.
- `err_len` out 1: sticky; `load_len` > DEPTH.
- `err_csum` out 1: sticky; checksum mismatch (see Configuration).

## Operation

- States: IDLE, CLEAR, LOAD, CHECK (present only with the macro), RUN.
- Reset: state IDLE. `cpu_rst`=1, `s_ready`=0, `busy`=0, `done`=0, `err_len`=0, `err_csum`=0. Memory contents are not reset.
- IDLE/RUN + `load_start`:
  - If `load_len` > DEPTH: set `err_len` and go to IDLE.
  - Otherwise latch `load_len`, clear both error flags and go to CLEAR. `cpu_rst` rises the same edge.
- `load_start` in CLEAR, LOAD or CHECK is ignored.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), then goes to LOAD. If latched length is 0, it goes straight to RUN.
- LOAD:
  - `s_ready`=1. A word transfers when `s_valid && s_ready`.
  - Words are written to addresses 0, 1, 2, … in arrival order. The write counter is ADDR_W+1 bits.
  - When the counter reaches the latched length, the next state is RUN, or CHECK with the macro. `s_ready` drops the cycle after the last accepted word.
- RUN: `cpu_rst`=0 and the core fetches freely. `done` pulses on the first RUN cycle.
- `fetch_instr`:
  - Combinational read of `mem[fetch_addr]`.
  - Forced to 0 while `busy` or `cpu_rst`.
  - Returns 0 for `fetch_addr` ≥ DEPTH when DEPTH is not a power of two.
- `rst` mid-load: immediate return to IDLE. Partial image is retained but unusable, since `cpu_rst`=1 until a full reload.

## Timing

- Load latency from `load_start` to `done`: 1 + DEPTH + N + stall cycles, plus 1 more with the checksum. N = `load_len`; stall cycles = cycles with `s_valid`=0 during LOAD.
- Memory write takes effect at the edge of acceptance and is readable combinationally the next cycle.
- `s_valid` may toggle freely; the loader never drops `s_ready` mid-LOAD except after the final word.
- `cpu_rst` falls on the same edge that enters RUN. The core's first fetch is address 0 on that cycle.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR of all loaded words is kept.
  - After N words, CHECK accepts one extra stream word (`s_ready`=1) and compares it to the XOR.
  - Match: go to RUN. Mismatch: set `err_csum`, go to IDLE, and keep `cpu_rst`=1.
- Macro undefined: no CHECK state, no extra word, and `err_csum` is tied to 0.

## Structure

- In package `definitions`:
  - `typedef enum logic [2:0] loader_state_e {LD_IDLE, LD_CLEAR, LD_LOAD, LD_CHECK, LD_RUN}`.
  - Constant `NOP_WORD = '0`.
- Sub-module `imem_ram`: DEPTH×DATA_W, one synchronous write port and one asynchronous read port. The loader instantiates it and owns all control.

## Test plan

- Reset then `load_start` with `load_len`=3 and words 32'h0C01000A, 32'h0C020014, 32'h00000000 sent back-to-back:
  - `done` arrives 1+64+3 cycles after start.
  - `fetch_instr`@0 = 32'h0C01000A, @2 = 0, @63 = 0.
  - `cpu_rst` falls with `done`.
- Same load with `s_valid` deasserted for 5 cycles between words 1 and 2: `done` is delayed by exactly 5 cycles and contents are identical.
- `load_len`=65 with DEPTH=64: `err_len`=1, state stays IDLE, `cpu_rst`=1 and memory is untouched.
- `load_len`=0: CLEAR then RUN. All 64 words read 0 and `done` is 65 cycles after start.
- `rst` asserted after the 2nd of 4 words: next cycle `s_ready`=0, `cpu_rst`=1, `fetch_instr`=0 and `busy`=0.
- Macro on, 2 words 32'h1, 32'h2:
  - Checksum word 32'h3 → RUN.
  - Repeat with checksum 32'h4 → `err_csum`=1, IDLE, `cpu_rst`=1.
